// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: buffers 16-bit HPS ioctl download words for one index
// in a small FIFO and replays each as a req/ack write to the SDRAM loader port.
// Optional build macro IOCTL_LOADER_CKSUM_EN adds a running 16-bit sum of
// acknowledged write data on output cksum.
module ioctl_sdram_loader #(
  parameter logic [7:0]  LOAD_INDEX = 8'h00,
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        load_busy,
  output logic        load_done,
  output logic        overflow
`ifdef IOCTL_LOADER_CKSUM_EN
  ,
  output logic [15:0] cksum
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_WAIT = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;

  logic [24:0]   fifo_addr [FIFO_DEPTH];
  logic [15:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  logic          dl_q;
  logic          req_nx;

  // Byte address bit 0 is meaningless for 16-bit words.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ioctl_addr[0];

  logic idx_match, accept, full, empty, push, pop, load_start;
  assign idx_match  = (ioctl_index == LOAD_INDEX);
  assign accept     = ioctl_wr & ioctl_download & idx_match;
  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign push       = accept & ~full;
  // Load a new head whenever the request slot is free or being freed this cycle.
  assign pop        = ~empty & (~mem_req | mem_ack);
  assign load_start = accept | (ioctl_download & ~dl_q & idx_match);

  // Next FIFO occupancy and request level, shared by wait and drain decisions.
  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + CNT_ONE;
    else if (!push && pop) count_nx = count - CNT_ONE;
    req_nx = mem_req;
    if (pop)          req_nx = 1'b1;
    else if (mem_ack) req_nx = 1'b0;
  end

  // FIFO storage; contents need no reset since pointers gate validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= BASE_ADDR + {ioctl_addr[24:1], 1'b0};
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  // FIFO pointers, SDRAM request channel, backpressure and sticky overflow.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        mem_addr <= fifo_addr[rd_ptr];
        mem_din  <= fifo_data[rd_ptr];
      end
      count      <= count_nx;
      mem_req    <= req_nx;
      ioctl_wait <= (count_nx >= CNT_WAIT);
      if (accept && full) overflow <= 1'b1;
    end
  end

  // Load sequencing; DONE is entered on the cycle the last ack is taken so
  // load_done lands one cycle after it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      dl_q      <= 1'b0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          state     <= LOAD;
          load_busy <= 1'b1;
        end
        LOAD: if (!ioctl_download) state <= DRAIN;
        DRAIN: begin
          if (ioctl_download && idx_match) begin
            state <= LOAD;
          end else if (count_nx == '0 && !req_nx) begin
            state     <= DONE;
            load_busy <= 1'b0;
            load_done <= 1'b1;
          end
        end
        DONE: begin
          if (load_start) begin
            state     <= LOAD;
            load_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IOCTL_LOADER_CKSUM_EN
  // Running sum of acknowledged write data, restarted when a new load begins.
  always_ff @(posedge clk_sys) begin
    if (reset)
      cksum <= '0;
    else if ((state == IDLE || state == DONE) && load_start)
      cksum <= '0;
    else if (mem_req && mem_ack)
      cksum <= cksum + mem_din;
  end
`endif

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Sits between the HPS ioctl download port and the SDRAM controller's loader write port inside pcfx_top.
- Accepts 16-bit ioctl words for one selected download index and buffers them in a small FIFO.
- Turns each buffered word into one req/ack write to SDRAM at BASE_ADDR + ioctl_addr.
- Throttles the HPS with ioctl_wait and holds the machine in reset until the last word is committed.

Parameters:
- LOAD_INDEX, 8'h00, ioctl_index value accepted (ROM BIOS); all other indices ignored.
- BASE_ADDR, 25'h0, SDRAM byte address added to ioctl_addr (ROM_BASE_A at instantiation).
- FIFO_DEPTH, 4, word FIFO depth; power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address; bit 0 ignored.
- ioctl_dout  in  16  write data, already in machine byte order.
- ioctl_wait  out  1  backpressure to HPS.
- mem_req  out  1  SDRAM write request, level.
- mem_ack  in  1  one-cycle accept from SDRAM controller.
- mem_addr  out  25  SDRAM byte address, bit 0 forced 0.
- mem_din  out  16  write data.
- load_busy  out  1  high from first accepted word until FIFO drained and download ended.
- load_done  out  1  one-cycle pulse at end of load.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high; it applies on the next clk_sys edge.
- Reset values: ioctl_wait=0, mem_req=0, mem_addr=0, mem_din=0, load_busy=0, load_done=0, overflow=0; FIFO empty; state IDLE.
- Word acceptance: a word is accepted when ioctl_wr & ioctl_download & (ioctl_index==LOAD_INDEX). The FIFO entry is {BASE_ADDR + {ioctl_addr[24:1],1'b0}} mod 2^25 (wraps) plus ioctl_dout.
- ioctl_wait: registered, =1 when FIFO count >= FIFO_DEPTH-1, evaluated after the current cycle's push/pop. This leaves room for one write the HPS already has in flight.
- Overflow: an accepted word with FIFO full is dropped and overflow is set. overflow clears only on reset.
- SDRAM handshake: when mem_req=0 and FIFO is non-empty, pop the head into mem_addr/mem_din and set mem_req next cycle. mem_req, mem_addr and mem_din hold stable until mem_ack.
- After mem_ack: mem_req drops the following cycle, unless the FIFO is non-empty. In that case the next word is loaded the same cycle, giving back-to-back requests with mem_req staying 1.
- mem_ack while mem_req=0 is ignored.
- Throughput: one word per mem_ack. Latency from accepted ioctl_wr to mem_req is 2 cycles when idle.
- Simultaneous push and pop: allowed; count unchanged.
- State machine:
  - IDLE: load_busy=0. Go to LOAD on the first accepted word, or on ioctl_download rising with a matching index.
  - LOAD: load_busy=1. Go to DRAIN when ioctl_download falls.
  - DRAIN: load_busy=1, no further pushes. Go to DONE when FIFO is empty and mem_req=0 (last ack taken).
  - DONE: load_done=1 for exactly one cycle, then IDLE.
  - LOAD re-entered from DRAIN if ioctl_download reasserts with a matching index; FIFO contents are preserved.
- Non-matching index downloads never change state, ioctl_wait or the FIFO.
- Reset mid-operation: FIFO flushed, mem_req drops immediately (next edge), no load_done pulse. Any in-progress SDRAM write is abandoned by the controller on the same reset.

Optional Feature:
- Macro IOCTL_LOADER_CKSUM_EN.
- When defined: adds output cksum[15:0] (reset 0). It holds the running 16-bit wrapping sum of mem_din over every acknowledged write and clears on IDLE->LOAD. It is stable from the load_done pulse until the next load starts.
- When undefined: no cksum port and no adder.

Test Plan:
- Basic load: index 0, 8 words 16'h0001..16'h0008 at ioctl_addr 0,2,..14, BASE_ADDR=25'h100000, mem_ack 1 cycle after each req -> SDRAM writes at 0x100000..0x10000E in order with matching data. load_done pulses once, 1 cycle after the last ack. With CKSUM_EN, cksum=16'h0024.
- Backpressure: FIFO_DEPTH=4, mem_ack held 0 for 20 cycles, HPS pushes 5 words honouring ioctl_wait -> ioctl_wait=1 once count>=3, no overflow, all 5 words written once ack resumes.
- Overflow: ignore ioctl_wait and push 6 words with no ack -> exactly 1 word dropped (the 6th), overflow=1 sticky; remaining words written in order.
- Index filter: download with ioctl_index=8'h01, 4 writes -> mem_req never asserts, load_busy stays 0, ioctl_wait stays 0.
- Address wrap and odd address: BASE_ADDR=25'h1FFFFFE, ioctl_addr=3 -> mem_addr=25'h0000000.
- Reset mid-load: assert reset while mem_req=1 with 2 words queued -> next cycle mem_req=0, load_busy=0, FIFO empty, no load_done.
